// File: rtl/detector_arbiter_if.sv
// Bundle between the detector arbiter, its requesters and the shared serial detector.
// The master side is the arbiter; the slave side is the requester/detector environment.
interface detector_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] bit_in;
    logic             det_y_in;
    logic [N_REQ-1:0] gnt;
    logic             det_x_out;
    logic             det_clr_out;
    logic             busy;
    logic             done;
    logic [1:0]       done_id;
    logic [CNT_W-1:0] hit_count;

    modport master (
        input  req, bit_in, det_y_in,
        output gnt, det_x_out, det_clr_out, busy, done, done_id, hit_count
    );

    modport slave (
        output req, bit_in, det_y_in,
        input  gnt, det_x_out, det_clr_out, busy, done, done_id, hit_count
    );
endinterface

// File: rtl/detector_arbiter.sv
// Round-robin time-sharing of one serial sequence detector among N_REQ requesters:
// clear, stream a fixed-length frame, count detector pulses, report with a done strobe.
module detector_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    detector_arbiter_if.master   bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam int              BC_W      = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HIT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]      LAST_INIT = 2'(N_REQ - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             done_q, done_d;
    logic [1:0]       done_id_q, done_id_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic [1:0]       pick_s;
    logic             pick_vld_s;
    logic [1:0]       idx_s;
    logic [CNT_W-1:0] hit_next_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == HIT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Round-robin pick: walk offsets from farthest to nearest so the nearest set request after last wins.
    always_comb begin
        pick_s     = last_q;
        pick_vld_s = 1'b0;
        idx_s      = 2'd0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx_s = 2'((int'(last_q) + off) % N_REQ);
            if (bus.req[idx_s]) begin
                pick_s     = idx_s;
                pick_vld_s = 1'b1;
            end
        end
    end

    // Detector pulse accumulated this cycle, saturating.
    always_comb begin
        if (bus.det_y_in) begin
            hit_next_s = sat_inc(hit_cnt_q);
        end else begin
            hit_next_s = hit_cnt_q;
        end
    end

    // Frame sequencing and result capture.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        hit_count_d = hit_count_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld_s) begin
                    sel_d   = pick_s;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                bit_cnt_d = '0;
                hit_cnt_d = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                hit_cnt_d = hit_next_s;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                // Last Moore sample lands here, so the result is latched on the way into REPORT.
                hit_cnt_d   = hit_next_s;
                hit_count_d = hit_next_s;
                done_id_d   = sel_q;
                done_d      = 1'b1;
                last_d      = sel_q;
                state_d     = S_REPORT;
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'd0;
            last_q      <= LAST_INIT;
            bit_cnt_q   <= '0;
            hit_cnt_q   <= '0;
            done_q      <= 1'b0;
            done_id_q   <= 2'd0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Grant and detector input follow the state directly so the bit reaches the detector in its own cycle.
    always_comb begin
        if (state_q == S_STREAM) begin
            bus.gnt       = N_REQ'(1'b1) << sel_q;
            bus.det_x_out = bus.bit_in[sel_q];
        end else begin
            bus.gnt       = '0;
            bus.det_x_out = 1'b0;
        end
    end

    assign bus.det_clr_out = (state_q == S_CLEAR);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.hit_count   = hit_count_q;

endmodule
